// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// neg_if works on a fixed NEG_W-bit container, so callers must keep 2*DPW < NEG_W.
package muldiv_pkg;

  localparam int unsigned DPW_DEF = 32;
  localparam int unsigned ADW_DEF = 5;
  localparam int unsigned NEG_W   = 128;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  function automatic logic [NEG_W-1:0] neg_if(input logic [NEG_W-1:0] val, input logic cond);
    return cond ? -val : val;
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide on
// operand magnitudes, sign fix-up at the end, one-cycle register-file write.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DPW = DPW_DEF,
  parameter int unsigned ADW = ADW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [DPW-1:0] rs1_val,
  input  logic [DPW-1:0] rs2_val,
  input  logic [ADW-1:0] rd_addr,
  output logic           busy,
  output logic           done,
  output logic           wb_we,
  output logic [ADW-1:0] wb_addr,
  output logic [DPW-1:0] wb_data
);

  localparam int unsigned CW = $clog2(DPW);

  muldiv_state_e    state, state_n;
  logic [CW-1:0]    cnt;
  logic [2*DPW-1:0] acc, acc_step;
  logic [DPW-1:0]   opnd;
  muldiv_op_e       op_q, op_in;
  logic [ADW-1:0]   rd_q;
  logic             sa_q, sb_q, div0_q;
  logic             sa_in, sb_in, is_div_q;
  logic [NEG_W-1:0] a_ext, b_ext, prod_ext, quot_ext, rem_ext;
  logic [DPW:0]     hi_sum, rem_sh;
  logic [DPW+1:0]   diff;
  logic [DPW-1:0]   result;
  logic             unused_bits;

  assign op_in    = muldiv_op_e'(op);
  assign sa_in    = is_signed_a(op_in) & rs1_val[DPW-1];
  assign sb_in    = is_signed_b(op_in) & rs2_val[DPW-1];
  assign a_ext    = neg_if(NEG_W'(rs1_val), sa_in);
  assign b_ext    = neg_if(NEG_W'(rs2_val), sb_in);
  assign is_div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_CALC;
      S_CALC: if (cnt == CW'(DPW - 1)) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    wb_we = (state == S_DONE) && (wb_addr != '0);
  end

  // Multiply: {hi,lo} with multiplier in lo, add multiplicand to hi, shift right.
  // Divide: {remainder,dividend/quotient}, shift left and trial-subtract divisor.
  always_comb begin
    hi_sum = {1'b0, acc[2*DPW-1:DPW]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = acc[2*DPW-1:DPW-1];
    diff   = {1'b0, rem_sh} - {2'b00, opnd};
    if (is_div_q) begin
      if (diff[DPW+1]) acc_step = {acc[2*DPW-2:0], 1'b0};
      else             acc_step = {diff[DPW-1:0], acc[DPW-2:0], 1'b1};
    end else begin
      acc_step = {hi_sum, acc[DPW-1:1]};
    end
  end

  always_comb begin
    prod_ext = neg_if(NEG_W'(acc), sa_q ^ sb_q);
    quot_ext = neg_if(NEG_W'(acc[DPW-1:0]), sa_q ^ sb_q);
    rem_ext  = neg_if(NEG_W'(acc[2*DPW-1:DPW]), sa_q);
    unique case (op_q)
      OP_MUL:                       result = prod_ext[DPW-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_ext[2*DPW-1:DPW];
      OP_DIV, OP_DIVU:              result = div0_q ? '1 : quot_ext[DPW-1:0];
      default:                      result = rem_ext[DPW-1:0];
    endcase
  end

  // Signed overflow and remainder-by-zero fall out of the magnitude datapath.
  assign unused_bits = ^{a_ext[NEG_W-1:DPW], b_ext[NEG_W-1:DPW], prod_ext[NEG_W-1:2*DPW],
                         quot_ext[NEG_W-1:DPW], rem_ext[NEG_W-1:DPW], diff[DPW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          op_q   <= op_in;
          rd_q   <= rd_addr;
          sa_q   <= sa_in;
          sb_q   <= sb_in;
          div0_q <= (rs2_val == '0);
          cnt    <= '0;
          if (op[2]) begin
            acc  <= {{DPW{1'b0}}, a_ext[DPW-1:0]};
            opnd <= b_ext[DPW-1:0];
          end else begin
            acc  <= {{DPW{1'b0}}, b_ext[DPW-1:0]};
            opnd <= a_ext[DPW-1:0];
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          wb_data <= result;
          wb_addr <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (DPW=32, ADW=5).
module tb_muldiv_unit;

  localparam int unsigned DPW = 32;
  localparam int unsigned ADW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op = '0;
  logic [DPW-1:0]  rs1_val = '0;
  logic [DPW-1:0]  rs2_val = '0;
  logic [ADW-1:0]  rd_addr = '0;
  logic            busy, done, wb_we;
  logic [ADW-1:0]  wb_addr;
  logic [DPW-1:0]  wb_data;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.DPW(DPW), .ADW(ADW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .busy(busy), .done(done), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle T; returns in cycle T+1 with operands scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    step();
    start = 1'b0;
    rs1_val = $urandom;
    rs2_val = $urandom;
    op = 3'($urandom);
    rd_addr = 5'($urandom);
  endtask

  // Runs one op; lat is the cycle offset of done (0 if never seen). Returns in T+lat+1.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic busy1,
                       output logic we, output logic [4:0] addr, output logic [31:0] data);
    lat = 0; we = 1'b0; addr = '0; data = '0;
    issue(o, a, b, rd);
    busy1 = busy;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c; we = wb_we; addr = wb_addr; data = wb_data;
        break;
      end
      step();
    end
    if (lat != 0) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb_we); end
    checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", wb_addr); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", wb_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic run_table(input string tag, input logic [2:0] ov[], input logic [31:0] av[],
                           input logic [31:0] bv[], input logic [31:0] ev[]);
    int lat; logic b1, we; logic [4:0] addr; logic [31:0] data;
    for (int i = 0; i < ov.size(); i++) begin
      logic [4:0] rd;
      rd = 5'(i + 5);
      do_op(ov[i], av[i], bv[i], rd, lat, b1, we, addr, data);
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL %s%0d_busy: got %b want 1", tag, i, b1); end
      checks++; if (lat != 34) begin errors++; $display("FAIL %s%0d_latency: got %0d want 34", tag, i, lat); end
      checks++; if (data !== ev[i]) begin errors++; $display("FAIL %s%0d_data: got %h want %h", tag, i, data, ev[i]); end
      checks++; if (addr !== rd) begin errors++; $display("FAIL %s%0d_addr: got %0d want %0d", tag, i, addr, rd); end
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL %s%0d_we: got %b want 1", tag, i, we); end
    end
  endtask

  task automatic test_mul();
    logic [2:0] ov[] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] av[] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev[] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    run_table("mul", ov, av, bv, ev);
  endtask

  task automatic test_div();
    logic [2:0] ov[] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av[] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv[] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    run_table("div", ov, av, bv, ev);
  endtask

  task automatic test_special();
    logic [2:0] ov[] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b110, 3'b101};
    logic [31:0] av[] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd5};
    logic [31:0] bv[] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] ev[] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    run_table("special", ov, av, bv, ev);
  endtask

  task automatic test_x0();
    int lat; logic b1, we; logic [4:0] addr; logic [31:0] data;
    do_op(3'b000, 32'd3, 32'd4, 5'd0, lat, b1, we, addr, data);
    checks++; if (lat != 34) begin errors++; $display("FAIL x0_latency: got %0d want 34", lat); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", we); end
    checks++; if (addr !== 5'd0) begin errors++; $display("FAIL x0_addr: got %0d want 0", addr); end
    checks++; if (data !== 32'd12) begin errors++; $display("FAIL x0_data: got %h want 0000000c", data); end
  endtask

  task automatic test_busy_ignore();
    int n_done = 0; int first = 0;
    logic [4:0] addr = '0; logic [31:0] data = '0;
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    repeat (9) step();
    op = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2; rd_addr = 5'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 11; c <= 50; c++) begin
      if (done) begin
        n_done++;
        if (first == 0) begin first = c; addr = wb_addr; data = wb_data; end
      end
      step();
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL ignore_count: got %0d dones want 1", n_done); end
    checks++; if (first != 34) begin errors++; $display("FAIL ignore_latency: got %0d want 34", first); end
    checks++; if (data !== 32'd14) begin errors++; $display("FAIL ignore_data: got %h want 0000000e", data); end
    checks++; if (addr !== 5'd3) begin errors++; $display("FAIL ignore_addr: got %0d want 3", addr); end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    logic [4:0] addr = '0; logic [31:0] data = '0;
    issue(3'b000, 32'd6, 32'd7, 5'd1);
    repeat (33) step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
    checks++; if (wb_data !== 32'd42) begin errors++; $display("FAIL b2b_first_data: got %h want 0000002a", wb_data); end
    op = 3'b011; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; rd_addr = 5'd2; start = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored: busy got %b want 0", busy); end
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
    for (int c = 1; c <= 50; c++) begin
      if (done) begin lat = c; addr = wb_addr; data = wb_data; break; end
      step();
    end
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    checks++; if (data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_data: got %h want fffffffe", data); end
    checks++; if (addr !== 5'd2) begin errors++; $display("FAIL b2b_addr: got %0d want 2", addr); end
    step();
  endtask

  task automatic test_reset_mid();
    int n_wr = 0;
    issue(3'b100, 32'd1000, 32'd3, 5'd7);
    repeat (14) step();
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b want 0", wb_we); end
    checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL midrst_addr: got %h want 0", wb_addr); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL midrst_data: got %h want 0", wb_data); end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wb_we || done) n_wr++;
      step();
    end
    checks++; if (n_wr != 0) begin errors++; $display("FAIL midrst_no_write: got %0d pulses want 0", n_wr); end
  endtask

  initial begin
    #1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_x0();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
